// File: rtl/rcdac8_pkg.sv
// Shared definitions for the eight-channel RC-filter DAC: timebase tap indices,
// output modes, register addresses and the config register layout.
package rcdac8_pkg;

  localparam int unsigned N100Clk = 0;
  localparam int unsigned U1Clk   = 1;
  localparam int unsigned U10Clk  = 2;
  localparam int unsigned U100Clk = 3;
  localparam int unsigned MxClk   = 3;

  localparam logic [3:0] DacCfgAddr = 4'h8;
  localparam logic [7:0] PwmLast    = 8'd254;

  typedef enum logic {
    DacPwm = 1'b0,
    DacPdm = 1'b1
  } dac_mode_e;

  typedef struct packed {
    dac_mode_e  mode;
    logic       invert;
    logic [1:0] clksrc;
    logic       enable;
    logic [2:0] spare;
  } dac_cfg_t;

  // PWM period is 255 ticks, so the counter wraps 254 -> 0.
  function automatic logic [7:0] pwm_next(input logic [7:0] p);
    return (p == PwmLast) ? 8'd0 : p + 8'd1;
  endfunction

endpackage

// File: rtl/rcdac8_dacchan.sv
// One DAC channel: live duty register, PDM accumulator and the registered
// PWM-compare / PDM-carry output bit.
module rcdac8_dacchan
  import rcdac8_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  dac_mode_e  mode_i,
  input  logic       tick_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] shadow_i,
  input  logic [7:0] pcount_i,
  output logic [7:0] active_o,
  output logic       out_o
);

  logic [7:0] active_q, active_d;
  logic [7:0] acc_q, acc_d;
  logic       out_q, out_d;
  logic [8:0] sum;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, active_q};
    active_d = load_i ? shadow_i : active_q;
    acc_d    = acc_q;
    out_d    = out_q;
    if (!enable_i || clear_i) begin
      acc_d = 8'd0;
      out_d = 1'b0;
    end else if (tick_i) begin
      if (mode_i == DacPwm) begin
        // Compare against the value going live so a new duty applies from pcount=0.
        out_d = (pcount_i < active_d);
      end else begin
        acc_d = sum[7:0];
        out_d = sum[8] | (active_q == 8'hFF);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 8'd0;
      acc_q    <= 8'd0;
      out_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
    end
  end

  assign active_o = active_q;
  assign out_o    = out_q;

endmodule

// File: rtl/rcdac8.sv
// Eight-channel RC-filter DAC slot peripheral: bus decode, config and shadow
// registers, the shared PWM period counter and timebase selection.
module rcdac8
  import rcdac8_pkg::*;
(
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             WE_I,
  input  logic             TGA_I,
  input  logic             STB_I,
  input  logic [7:0]       ADR_I,
  output logic             STALL_O,
  output logic             ACK_O,
  input  logic [7:0]       DAT_I,
  output logic [7:0]       DAT_O,
  input  logic [MxClk:0]   clocks,
  inout  wire  [7:0]       pins
);

  dac_cfg_t   cfg_q, cfg_d;
  logic [7:0] shadow_q [8];
  logic [7:0] shadow_d [8];
  logic [7:0] pcount_q, pcount_d, pcount_nxt;
  logic [7:0] active [8];
  logic [7:0] outreg;
  logic       myaddr, reg_wr, cfg_wr, mode_chg;
  logic       tick_src, tick, wrap, load;

  always_comb begin
    myaddr   = STB_I & (ADR_I[7:4] == 4'h0);
    reg_wr   = myaddr & TGA_I & WE_I;
    cfg_wr   = reg_wr & (ADR_I[3:0] == DacCfgAddr);
    mode_chg = cfg_wr & (DAT_I[7] != cfg_q.mode);

    unique case (cfg_q.clksrc)
      2'd0:    tick_src = clocks[N100Clk];
      2'd1:    tick_src = clocks[U1Clk];
      2'd2:    tick_src = clocks[U10Clk];
      default: tick_src = clocks[U100Clk];
    endcase

    // A mode switch wins over any tick in the same cycle: counters restart clean.
    tick       = tick_src & cfg_q.enable & ~mode_chg;
    pcount_nxt = pwm_next(pcount_q);
    wrap       = (pcount_q == PwmLast);
    load       = ~cfg_q.enable | (tick & ((cfg_q.mode == DacPwm) ? wrap : 1'b1));

    pcount_d = pcount_q;
    if (!cfg_q.enable || mode_chg) begin
      pcount_d = 8'd0;
    end else if (tick && (cfg_q.mode == DacPwm)) begin
      pcount_d = pcount_nxt;
    end

    for (int i = 0; i < 8; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (reg_wr && !ADR_I[3]) begin
      shadow_d[ADR_I[2:0]] = DAT_I;
    end

    cfg_d = cfg_wr ? dac_cfg_t'(DAT_I) : cfg_q;
  end

  always_comb begin
    DAT_O = DAT_I;
    if (myaddr) begin
      if (!TGA_I) begin
        DAT_O = 8'h00;
      end else if (!ADR_I[3]) begin
        DAT_O = active[ADR_I[2:0]];
      end else if (ADR_I[3:0] == DacCfgAddr) begin
        DAT_O = cfg_q;
      end else begin
        DAT_O = 8'h00;
      end
    end
  end

  assign ACK_O   = myaddr;
  assign STALL_O = 1'b0;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cfg_q    <= '0;
      pcount_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 8'd0;
      end
    end else begin
      cfg_q    <= cfg_d;
      pcount_q <= pcount_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_chan
    rcdac8_dacchan u_chan (
      .clk_i    (CLK_I),
      .rst_i    (RST_I),
      .enable_i (cfg_q.enable),
      .mode_i   (cfg_q.mode),
      .tick_i   (tick),
      .clear_i  (mode_chg),
      .load_i   (load),
      .shadow_i (shadow_q[g]),
      .pcount_i (pcount_nxt),
      .active_o (active[g]),
      .out_o    (outreg[g])
    );

    assign pins[g] = cfg_q.enable ? (outreg[g] ^ cfg_q.invert) : 1'bz;
  end

endmodule

// File: tb/tb_rcdac8.sv
// Directed bench for rcdac8: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_rcdac8;
  import rcdac8_pkg::*;

  logic             clk;
  logic             rst;
  logic             we, tga, stb;
  logic [7:0]       adr, dat_i;
  logic             stall, ack;
  logic [7:0]       dat_o;
  logic [MxClk:0]   clocks;
  wire  [7:0]       pins;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  rcdac8 dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .WE_I    (we),
    .TGA_I   (tga),
    .STB_I   (stb),
    .ADR_I   (adr),
    .STALL_O (stall),
    .ACK_O   (ack),
    .DAT_I   (dat_i),
    .DAT_O   (dat_o),
    .clocks  (clocks),
    .pins    (pins)
  );

  // Undriven (hi-Z) pins read back as 1.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (pins[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    stb = 1'b1; tga = 1'b1; we = 1'b1; adr = a; dat_i = d;
    cyc();
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    stb = 1'b1; tga = 1'b1; we = 1'b0; adr = a;
    #1;
    d = dat_o;
    stb = 1'b0;
  endtask

  task automatic count_hi(input int n, input int ch, output int c);
    c = 0;
    repeat (n) begin
      cyc();
      if (pins[ch] === 1'b1) c++;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] others;
    int         c0, c1;

    rst = 1'b1; we = 1'b0; tga = 1'b0; stb = 1'b0; adr = 8'h00; dat_i = 8'h00;
    clocks = 4'b0001;
    cyc(); cyc();
    push("rst_pins_hiz", 32'hFF); pop_check({24'h0, pins});
    rd(8'h08, d); push("rst_cfg", 32'h00); pop_check({24'h0, d});
    rst = 1'b0;
    cyc();

    // PWM duty 64 on channel 0
    wr(8'h00, 8'd64);
    wr(8'h08, 8'h08);
    rd(8'h08, d); push("cfg_readback", 32'h08); pop_check({24'h0, d});
    for (int p = 0; p < 2; p++) begin
      c0 = 0; others = '0;
      repeat (255) begin
        cyc();
        if (pins[0] === 1'b1) c0++;
        others |= pins[7:1];
      end
      push("pwm64_high_ticks", 32'd64); pop_check(c0);
      push("pwm64_other_pins", 32'd0);  pop_check({25'h0, others});
    end

    // Duty 0 and 255 extremes, then invert
    wr(8'h00, 8'd0);
    wr(8'h01, 8'd255);
    repeat (256) cyc();
    c0 = 0; c1 = 0;
    repeat (765) begin
      cyc();
      if (pins[0] === 1'b1) c0++;
      if (pins[1] === 1'b1) c1++;
    end
    push("duty0_high_ticks", 32'd0);     pop_check(c0);
    push("duty255_high_ticks", 32'd765); pop_check(c1);
    push("pins_before_inv", 32'h02);     pop_check({24'h0, pins});
    wr(8'h08, 8'h48);
    push("pins_inverted", 32'hFD);       pop_check({24'h0, pins});
    wr(8'h08, 8'h08);

    // Mid-period duty write, visible only from the wrap
    wr(8'h08, 8'h00);
    push("disable_hiz", 32'hFF); pop_check({24'h0, pins});
    wr(8'h08, 8'h08);
    repeat (100) cyc();
    wr(8'h00, 8'd200);
    rd(8'h00, d); push("reg0_old_after_write", 32'd0); pop_check({24'h0, d});
    repeat (153) cyc();
    push("pin0_before_wrap", 32'd0);  pop_check({31'h0, pins[0]});
    rd(8'h00, d); push("reg0_before_wrap", 32'd0); pop_check({24'h0, d});
    cyc();
    push("pin0_at_wrap", 32'd1);      pop_check({31'h0, pins[0]});
    rd(8'h00, d); push("reg0_after_wrap", 32'd200); pop_check({24'h0, d});
    count_hi(255, 0, c0);
    push("pwm200_high_ticks", 32'd200); pop_check(c0);

    // PDM
    wr(8'h00, 8'd128);
    wr(8'h08, 8'h80);
    wr(8'h08, 8'h88);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      push($sformatf("pdm128_tick%0d", k), (k % 2 == 0) ? 32'd1 : 32'd0);
      pop_check({31'h0, pins[0]});
    end
    wr(8'h00, 8'd1);
    cyc();
    count_hi(256, 0, c0);
    push("pdm1_ones_per_256", 32'd1);   pop_check(c0);
    wr(8'h00, 8'd255);
    cyc(); cyc();
    count_hi(256, 0, c0);
    push("pdm255_ones_per_256", 32'd256); pop_check(c0);

    // Disable, poll, re-enable restarts the period counter
    wr(8'h08, 8'h80);
    push("pdm_disable_hiz", 32'hFF); pop_check({24'h0, pins});
    stb = 1'b1; tga = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'hA5;
    #1;
    push("poll_ack", 32'd1);  pop_check({31'h0, ack});
    push("poll_data", 32'h00); pop_check({24'h0, dat_o});
    push("stall", 32'd0);     pop_check({31'h0, stall});
    stb = 1'b0;
    wr(8'h00, 8'd64);
    wr(8'h08, 8'h08);
    push("reenable_pin0", 32'd0); pop_check({31'h0, pins[0]});
    count_hi(63, 0, c0);
    push("reenable_first_highs", 32'd63); pop_check(c0);
    cyc();
    push("reenable_pcount64_low", 32'd0); pop_check({31'h0, pins[0]});
    rd(8'h08, d); push("cfg_readback2", 32'h08); pop_check({24'h0, d});
    wr(8'h09, 8'hFF);
    rd(8'h09, d); push("reg9_reads_zero", 32'h00); pop_check({24'h0, d});
    rd(8'h08, d); push("reg9_write_ignored", 32'h08); pop_check({24'h0, d});

    // Select an idle timebase: outputs freeze
    wr(8'h08, 8'h18);
    count_hi(300, 0, c0);
    push("clksrc_idle_freeze", 32'd0); pop_check(c0);
    wr(8'h08, 8'h08);
    repeat (50) cyc();

    // Asynchronous reset mid-period
    #2;
    rst = 1'b1;
    #1;
    push("async_rst_hiz", 32'hFF); pop_check({24'h0, pins});
    rd(8'h08, d); push("async_rst_cfg", 32'h00); pop_check({24'h0, d});
    rd(8'h00, d); push("async_rst_active0", 32'h00); pop_check({24'h0, d});
    stb = 1'b1; tga = 1'b1; we = 1'b0; adr = 8'h10; dat_i = 8'h5A;
    #1;
    push("foreign_addr_ack", 32'd0);   pop_check({31'h0, ack});
    push("foreign_addr_pass", 32'h5A); pop_check({24'h0, dat_o});
    stb = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    rd(8'h01, d); push("shadow1_cleared", 32'h00); pop_check({24'h0, d});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
